// File: rtl/bsg_counter_overflow_set_en_step.sv
// Up-counter with load, variable step, terminal-count detect and wrap/saturate
// behaviour. wrap_o pulses for one cycle after each crossing, sticky_o latches
// crossings until cleared. Reset asserts asynchronously and releases
// synchronously through a two-stage synchroniser.
module bsg_counter_overflow_set_en_step #(
  parameter int unsigned width_p      = 32,
  parameter int unsigned max_val_p    = 1000,
  parameter int unsigned step_width_p = 4,
  parameter int unsigned wrap_p       = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    en_i,
  input  logic [step_width_p-1:0] step_i,
  input  logic                    set_i,
  input  logic [width_p-1:0]      val_i,
  input  logic                    clear_i,
  output logic [width_p-1:0]      count_o,
  output logic                    overflow_o,
  output logic                    wrap_o,
  output logic                    sticky_o
);

  localparam int unsigned sum_w_lp = width_p + 1;

  // Largest value a width_p-bit counter can hold, computed at 64 bits.
  localparam logic [63:0] cnt_lim_lp =
    (width_p >= 64) ? {64{1'b1}} : ((64'd1 << width_p) - 64'd1);
  localparam logic [63:0] step_lim_lp =
    (step_width_p >= 64) ? {64{1'b1}} : ((64'd1 << step_width_p) - 64'd1);

  localparam logic [width_p-1:0]  max_lp     = width_p'(max_val_p);
  localparam logic [sum_w_lp-1:0] max_ext_lp = sum_w_lp'(max_val_p);
  localparam logic [sum_w_lp-1:0] modulus_lp = max_ext_lp + sum_w_lp'(1);

  // Elaboration-time parameter legality checks.
  if (width_p < 1) begin : g_bad_width
    $error("bsg_counter_overflow_set_en_step: width_p must be >= 1");
  end
  if (max_val_p < 1 || 64'(max_val_p) > cnt_lim_lp) begin : g_bad_max
    $error("bsg_counter_overflow_set_en_step: max_val_p out of range for width_p");
  end
  if (step_width_p < 1 || step_lim_lp > (64'(max_val_p) + 64'd1)) begin : g_bad_step
    $error("bsg_counter_overflow_set_en_step: step_width_p too wide for max_val_p");
  end
  if (wrap_p > 1) begin : g_bad_wrap
    $error("bsg_counter_overflow_set_en_step: wrap_p must be 0 or 1");
  end

  logic [1:0]          rst_sync_q;
  logic                core_rst_n;
  logic [width_p-1:0]  count_q, count_n;
  logic                wrap_q, sticky_q, sticky_n;
  logic [sum_w_lp-1:0] sum;
  logic                crossing;

  // Reset synchroniser: asserts immediately, releases after two clk_i edges.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign core_rst_n = rst_sync_q[1];

  // Next-state: set beats enable beats hold; crossing wraps or saturates.
  always_comb begin
    count_n  = count_q;
    sum      = {1'b0, count_q} + sum_w_lp'(step_i);
    crossing = 1'b0;
    if (set_i) begin
      count_n = (val_i > max_lp) ? max_lp : val_i;
    end else if (en_i) begin
      if (sum > max_ext_lp) begin
        crossing = 1'b1;
        count_n  = (wrap_p != 0) ? width_p'(sum - modulus_lp) : max_lp;
      end else begin
        count_n = width_p'(sum);
      end
    end
    sticky_n = crossing | (sticky_q & ~clear_i);
  end

  // State registers; held in reset while the synchronised reset is low.
  always_ff @(posedge clk_i or negedge core_rst_n) begin
    if (!core_rst_n) begin
      count_q  <= '0;
      wrap_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      count_q  <= count_n;
      wrap_q   <= crossing;
      sticky_q <= sticky_n;
    end
  end

  assign count_o    = count_q;
  assign wrap_o     = wrap_q;
  assign sticky_o   = sticky_q;
  assign overflow_o = (count_q == max_lp);

endmodule

// File: tb/tb_bsg_counter_overflow_set_en_step.sv
// Directed bench: one wrapping and one saturating instance (width 8, max 9,
// step width 2) share stimulus; each scenario checks {count, overflow, wrap,
// sticky} of both instances against hand-computed values.
module tb_bsg_counter_overflow_set_en_step;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en, set, clear;
  logic [1:0] step;
  logic [7:0] val;

  logic [7:0] cnt_w, cnt_s;
  logic       ovf_w, ovf_s, wrp_w, wrp_s, stk_w, stk_s;
  logic [10:0] obs_w, obs_s, e;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  bsg_counter_overflow_set_en_step #(
    .width_p(8), .max_val_p(9), .step_width_p(2), .wrap_p(1)
  ) dut_w (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .step_i(step), .set_i(set),
    .val_i(val), .clear_i(clear), .count_o(cnt_w), .overflow_o(ovf_w),
    .wrap_o(wrp_w), .sticky_o(stk_w)
  );

  bsg_counter_overflow_set_en_step #(
    .width_p(8), .max_val_p(9), .step_width_p(2), .wrap_p(0)
  ) dut_s (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .step_i(step), .set_i(set),
    .val_i(val), .clear_i(clear), .count_o(cnt_s), .overflow_o(ovf_s),
    .wrap_o(wrp_s), .sticky_o(stk_s)
  );

  // Observation vector: {count[7:0], overflow, wrap, sticky}
  assign obs_w = {cnt_w, ovf_w, wrp_w, stk_w};
  assign obs_s = {cnt_s, ovf_s, wrp_s, stk_s};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [7:0] v, input logic n,
                       input logic [1:0] st, input logic c);
    set = s; val = v; en = n; step = st; clear = c;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 2'd0, 1'b0);
    repeat (2) tick();
    e = {8'd0, 3'b000}; checks++;
    if (obs_w !== e) $display("FAIL reset_w got %h exp %h", obs_w, e); else passes++;
    checks++;
    if (obs_s !== e) $display("FAIL reset_s got %h exp %h", obs_s, e); else passes++;
    reset_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (obs_w !== e) $display("FAIL post_reset_idle_w got %h exp %h", obs_w, e); else passes++;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'd8, 1'b0, 2'd0, 1'b0); tick();
    drive(1'b0, 8'd0, 1'b1, 2'd3, 1'b0); tick();
    drive(1'b1, 8'd5, 1'b0, 2'd0, 1'b0); tick();
    drive(1'b0, 8'd0, 1'b0, 2'd0, 1'b0);
    e = {8'd5, 3'b001}; checks++;
    if (obs_w !== e) $display("FAIL pre_mid_reset_w got %h exp %h", obs_w, e); else passes++;
    #2 reset_n = 1'b0;
    #1;
    e = {8'd0, 3'b000}; checks++;
    if (obs_w !== e) $display("FAIL mid_reset_w got %h exp %h", obs_w, e); else passes++;
    checks++;
    if (obs_s !== e) $display("FAIL mid_reset_s got %h exp %h", obs_s, e); else passes++;
    drive(1'b1, 8'd7, 1'b1, 2'd3, 1'b0);
    repeat (2) tick();
    checks++;
    if (obs_w !== e) $display("FAIL reset_ignores_inputs_w got %h exp %h", obs_w, e); else passes++;
    drive(1'b0, 8'd0, 1'b0, 2'd0, 1'b0);
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_wrap();
    drive(1'b1, 8'd8, 1'b0, 2'd0, 1'b0); tick();
    drive(1'b0, 8'd0, 1'b1, 2'd3, 1'b0); tick();
    e = {8'd1, 3'b011}; checks++;
    if (obs_w !== e) $display("FAIL wrap_w got %h exp %h", obs_w, e); else passes++;
    e = {8'd9, 3'b111}; checks++;
    if (obs_s !== e) $display("FAIL sat_first_s got %h exp %h", obs_s, e); else passes++;
    drive(1'b0, 8'd0, 1'b0, 2'd0, 1'b0); tick();
    e = {8'd1, 3'b001}; checks++;
    if (obs_w !== e) $display("FAIL wrap_pulse_end_w got %h exp %h", obs_w, e); else passes++;
  endtask

  task automatic test_saturate();
    drive(1'b0, 8'd0, 1'b1, 2'd1, 1'b0); tick();
    e = {8'd9, 3'b111}; checks++;
    if (obs_s !== e) $display("FAIL sat_again_s got %h exp %h", obs_s, e); else passes++;
    e = {8'd2, 3'b001}; checks++;
    if (obs_w !== e) $display("FAIL sat_again_w got %h exp %h", obs_w, e); else passes++;
  endtask

  task automatic test_exact_hit();
    drive(1'b0, 8'd0, 1'b0, 2'd0, 1'b1); tick();
    e = {8'd9, 3'b100}; checks++;
    if (obs_s !== e) $display("FAIL clear_only_s got %h exp %h", obs_s, e); else passes++;
    drive(1'b1, 8'd6, 1'b0, 2'd0, 1'b0); tick();
    drive(1'b0, 8'd0, 1'b1, 2'd3, 1'b0); tick();
    e = {8'd9, 3'b100}; checks++;
    if (obs_w !== e) $display("FAIL exact_hit_w got %h exp %h", obs_w, e); else passes++;
    checks++;
    if (obs_s !== e) $display("FAIL exact_hit_s got %h exp %h", obs_s, e); else passes++;
  endtask

  task automatic test_set_priority();
    drive(1'b1, 8'd12, 1'b1, 2'd3, 1'b0); tick();
    e = {8'd9, 3'b100}; checks++;
    if (obs_w !== e) $display("FAIL set_clamp_w got %h exp %h", obs_w, e); else passes++;
    checks++;
    if (obs_s !== e) $display("FAIL set_clamp_s got %h exp %h", obs_s, e); else passes++;
    drive(1'b1, 8'd3, 1'b1, 2'd3, 1'b0); tick();
    e = {8'd3, 3'b000}; checks++;
    if (obs_w !== e) $display("FAIL set_over_en_w got %h exp %h", obs_w, e); else passes++;
    drive(1'b0, 8'd0, 1'b1, 2'd0, 1'b0); tick();
    checks++;
    if (obs_w !== e) $display("FAIL step_zero_hold_w got %h exp %h", obs_w, e); else passes++;
    drive(1'b0, 8'd0, 1'b0, 2'd3, 1'b0); tick();
    checks++;
    if (obs_w !== e) $display("FAIL en_low_hold_w got %h exp %h", obs_w, e); else passes++;
  endtask

  task automatic test_clear_collision();
    drive(1'b1, 8'd9, 1'b0, 2'd0, 1'b0); tick();
    drive(1'b0, 8'd0, 1'b1, 2'd1, 1'b0); tick();
    drive(1'b1, 8'd9, 1'b0, 2'd0, 1'b0); tick();
    e = {8'd9, 3'b101}; checks++;
    if (obs_w !== e) $display("FAIL collide_setup_w got %h exp %h", obs_w, e); else passes++;
    drive(1'b0, 8'd0, 1'b1, 2'd1, 1'b1); tick();
    e = {8'd0, 3'b011}; checks++;
    if (obs_w !== e) $display("FAIL collide_w got %h exp %h", obs_w, e); else passes++;
    e = {8'd9, 3'b111}; checks++;
    if (obs_s !== e) $display("FAIL collide_s got %h exp %h", obs_s, e); else passes++;
    drive(1'b0, 8'd0, 1'b0, 2'd0, 1'b1); tick();
    e = {8'd0, 3'b000}; checks++;
    if (obs_w !== e) $display("FAIL clear_after_w got %h exp %h", obs_w, e); else passes++;
    e = {8'd9, 3'b100}; checks++;
    if (obs_s !== e) $display("FAIL clear_after_s got %h exp %h", obs_s, e); else passes++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 8'd9, 1'b0, 2'd0, 1'b0); tick();
    drive(1'b0, 8'd0, 1'b1, 2'd3, 1'b0); tick();
    e = {8'd2, 3'b011}; checks++;
    if (obs_w !== e) $display("FAIL b2b1_w got %h exp %h", obs_w, e); else passes++;
    e = {8'd9, 3'b111}; checks++;
    if (obs_s !== e) $display("FAIL b2b1_s got %h exp %h", obs_s, e); else passes++;
    tick();
    e = {8'd5, 3'b001}; checks++;
    if (obs_w !== e) $display("FAIL b2b2_w got %h exp %h", obs_w, e); else passes++;
    e = {8'd9, 3'b111}; checks++;
    if (obs_s !== e) $display("FAIL b2b2_s got %h exp %h", obs_s, e); else passes++;
    drive(1'b0, 8'd0, 1'b1, 2'd2, 1'b0); tick();
    e = {8'd7, 3'b001}; checks++;
    if (obs_w !== e) $display("FAIL b2b3_w got %h exp %h", obs_w, e); else passes++;
    e = {8'd9, 3'b111}; checks++;
    if (obs_s !== e) $display("FAIL b2b3_s got %h exp %h", obs_s, e); else passes++;
    drive(1'b0, 8'd0, 1'b0, 2'd0, 1'b0); tick();
    e = {8'd9, 3'b101}; checks++;
    if (obs_s !== e) $display("FAIL b2b_end_s got %h exp %h", obs_s, e); else passes++;
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_wrap();
    test_saturate();
    test_exact_hit();
    test_set_priority();
    test_clear_collision();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bsg_counter_overflow_set_en_step.md
BSG_COUNTER_OVERFLOW_SET_EN_STEP -- requirements
Module: bsg_counter_overflow_set_en_step

Interface
REQ-001 Parameter width_p, default 32: counter width in bits.
REQ-002 Parameter max_val_p, default 1000: terminal count; legal range 1 <= max_val_p <= 2^width_p - 1.
REQ-003 Parameter step_width_p, default 4: width of the increment input; legal only if 2^step_width_p - 1 <= max_val_p + 1.
REQ-004 Parameter wrap_p, default 1: 1 = wrap modulo (max_val_p+1); 0 = saturate at max_val_p.
REQ-005 Illegal parameter combinations SHALL stop elaboration with an error message.
REQ-006 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset_n_i  input  1  reset, asynchronous, active-low.
REQ-008 en_i  input  1  advance the count by step_i this cycle.
REQ-009 step_i  input  step_width_p  unsigned increment; 0 is a legal no-op.
REQ-010 set_i  input  1  load val_i this cycle.
REQ-011 val_i  input  width_p  load value.
REQ-012 clear_i  input  1  clear sticky_o.
REQ-013 count_o  output  width_p  registered count.
REQ-014 overflow_o  output  1  combinational; high iff count_o == max_val_p.
REQ-015 wrap_o  output  1  registered one-cycle pulse flagging a crossing in the previous cycle.
REQ-016 sticky_o  output  1  registered; set by a crossing, held until cleared.

Function
REQ-017 Priority per cycle SHALL be set_i, then en_i, then hold.
REQ-018 set_i=1: next count = min(val_i, max_val_p); no crossing; en_i and step_i ignored.
REQ-019 set_i=0, en_i=1: sum = count_o + step_i computed at width_p+1 bits with no truncation.
REQ-020 sum <= max_val_p: next count = sum; no crossing.
REQ-021 sum > max_val_p is a crossing.
REQ-022 Crossing with wrap_p=1: next count = sum - (max_val_p+1); one subtraction suffices given REQ-003.
REQ-023 Crossing with wrap_p=0: next count = max_val_p.
REQ-024 With wrap_p=0 and count_o == max_val_p, every en_i with step_i > 0 is a crossing; count stays at max_val_p.
REQ-025 step_i = 0 never causes a crossing, and the count holds.
REQ-026 set_i=0, en_i=0: count holds. Unlike the prior generation, overflow_o never auto-clears the count.
REQ-027 wrap_o SHALL be high in the cycle after a crossing and low otherwise; back-to-back crossings give back-to-back pulses.
REQ-028 sticky_o SHALL become 1 on a crossing and become 0 on clear_i; if both occur in the same cycle, it SHALL be 1 (set wins).
REQ-029 clear_i SHALL NOT affect count_o or wrap_o.
REQ-030 Latency: all inputs affect registered outputs at the next rising edge; overflow_o follows count_o combinationally.

Reset
REQ-031 reset_n_i low SHALL immediately force count_o=0, wrap_o=0 and sticky_o=0, regardless of clk_i.
REQ-032 While reset_n_i is low, all inputs SHALL be ignored.
REQ-033 Deassertion SHALL be synchronised internally, and the first update occurs on the first rising edge after release is synchronised.
REQ-034 After reset, overflow_o SHALL equal 0.

Verification (max_val_p=9, step_width_p=2, width_p=8 unless stated)
REQ-035 Reset mid-operation: count_o=5, drop reset_n_i between edges -> count_o=0, sticky_o=0 and wrap_o=0 before the next edge.
REQ-036 Wrap with wrap_p=1: count_o=8, en_i=1, step_i=3 -> count_o=1; the next cycle shows wrap_o=1 and sticky_o=1; wrap_o=0 the following cycle.
REQ-037 Saturate with wrap_p=0: count_o=8, step_i=3 -> count_o=9, overflow_o=1, wrap_o pulses; then step_i=1 -> count_o stays 9 and wrap_o pulses again.
REQ-038 Exact hit: count_o=6, step_i=3 -> count_o=9, overflow_o=1, wrap_o=0, sticky_o unchanged.
REQ-039 Set priority: set_i=1, val_i=12, en_i=1, step_i=3 -> count_o=9 (clamped), no wrap_o pulse.
REQ-040 Clear collision: count_o=9, wrap_p=1, step_i=1, clear_i=1 with sticky_o=1 -> count_o=0, sticky_o stays 1; clear_i alone on the next cycle -> sticky_o=0.
